depacketizer_4_serial: RTL

Receive-side counterpart of the 4-flit packetizer. Accepts one NoC flit per cycle from a router egress port, checks the head/tail framing, strips the headers and padding, and reassembles the original data word. Delivers the word with its VC and destination under a valid/ready handshake. Sits between a NoC output port and the consuming module's input.

---
 rtl/depacketizer_4_serial_if.sv | 38 +++
 rtl/depacketizer_4_serial.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/depacketizer_4_serial_if.sv
// Flit ingress and word egress bundle for depacketizer_4_serial.
// slave: the depacketizer; master: NoC egress port plus consumer side.
interface depacketizer_4_serial_if #(
    parameter int unsigned ADDRESS_WIDTH    = 4,
    parameter int unsigned VC_ADDRESS_WIDTH = 1,
    parameter int unsigned WIDTH_PKT        = 36,
    parameter int unsigned WIDTH_DATA       = 12
);
    localparam int unsigned F = WIDTH_PKT / 4;

    logic [F-1:0]                flit_in;
    logic                        ready_out;
    logic [WIDTH_DATA-1:0]       data_out;
    logic [ADDRESS_WIDTH-1:0]    dst_out;
    logic [VC_ADDRESS_WIDTH-1:0] vc_out;
    logic                        valid_out;
    logic                        ready_in;

    modport slave (
        input  flit_in,
        input  ready_in,
        output ready_out,
        output data_out,
        output dst_out,
        output vc_out,
        output valid_out
    );

    modport master (
        output flit_in,
        output ready_in,
        input  ready_out,
        input  data_out,
        input  dst_out,
        input  vc_out,
        input  valid_out
    );
endinterface

// File: rtl/depacketizer_4_serial.sv
// Receive-side depacketizer: checks head/tail framing of incoming NoC flits,
// strips headers and padding, and reassembles the data word for a consumer.
// Optional macro DEPKT_VC_CHECK_EN: drop packets whose body flit vc differs
// from the vc latched from the head flit.
module depacketizer_4_serial #(
    parameter int unsigned ADDRESS_WIDTH    = 4,
    parameter int unsigned VC_ADDRESS_WIDTH = 1,
    parameter int unsigned WIDTH_PKT        = 36,
    parameter int unsigned WIDTH_DATA       = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    depacketizer_4_serial_if.slave bus,
    output logic                  err_out,
    output logic [7:0]            drop_cnt
);
    localparam int unsigned F       = WIDTH_PKT / 4;
    localparam int unsigned P1      = F - 3 - ADDRESS_WIDTH - VC_ADDRESS_WIDTH;
    localparam int unsigned P       = F - 3 - VC_ADDRESS_WIDTH;
    localparam int unsigned REM     = (WIDTH_DATA > P1) ? (WIDTH_DATA - P1) : 0;
    localparam int unsigned N_FLITS = 1 + (REM + P - 1) / P;
    // Shift buffer holds every payload slot; padding of the last flit lands at its LSBs.
    localparam int unsigned W_BUF   = P1 + (N_FLITS - 1) * P;
    localparam int unsigned IDX_W   = $clog2(N_FLITS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BODY = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t state, state_next, head_next;

    logic [F-1:0]                flit;
    logic                        f_valid, f_head, f_tail;
    logic [VC_ADDRESS_WIDTH-1:0] f_vc;
    logic [ADDRESS_WIDTH-1:0]    f_dst;
    logic [P1-1:0]               f_head_pl;
    logic [P-1:0]                f_body_pl;

    logic                        ready_c, acc, body_last, vc_ok;
    logic                        head_c, body_c, done_c, drop_c;
    logic [W_BUF-1:0]            buf_q, buf_c;
    logic [WIDTH_DATA-1:0]       word_c;
    logic [IDX_W-1:0]            idx_q;
    logic [VC_ADDRESS_WIDTH-1:0] vc_q;
    logic [ADDRESS_WIDTH-1:0]    dst_q;

    logic [WIDTH_DATA-1:0]       data_q;
    logic [ADDRESS_WIDTH-1:0]    dst_out_q;
    logic [VC_ADDRESS_WIDTH-1:0] vc_out_q;
    logic                        valid_q;

    // Flit field decode, MSB first: valid, head, tail, vc, dst, payload.
    assign flit      = bus.flit_in;
    assign f_valid   = flit[F-1];
    assign f_head    = flit[F-2];
    assign f_tail    = flit[F-3];
    assign f_vc      = flit[F-4 -: VC_ADDRESS_WIDTH];
    assign f_dst     = flit[F-4-VC_ADDRESS_WIDTH -: ADDRESS_WIDTH];
    assign f_head_pl = flit[P1-1:0];
    assign f_body_pl = flit[P-1:0];

    // Backpressure only while a finished word waits for the consumer.
    assign ready_c       = (state != S_HOLD) | bus.ready_in;
    assign bus.ready_out = ready_c;
    assign acc           = f_valid & ready_c;

    assign body_last = (32'(idx_q) + 32'd1) == 32'(N_FLITS);
    assign head_next = (N_FLITS == 1) ? (f_tail ? S_HOLD : S_IDLE) : S_BODY;

`ifdef DEPKT_VC_CHECK_EN
    assign vc_ok = (f_vc == vc_q);
`else
    assign vc_ok = 1'b1;
`endif

    // Head loads the buffer; each body flit shifts its full payload slot in.
    assign buf_c  = head_c ? W_BUF'(f_head_pl) : W_BUF'({buf_q, f_body_pl});
    assign word_c = buf_c[W_BUF-1 -: WIDTH_DATA];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (acc && f_head) begin
                    state_next = head_next;
                end
            end
            S_BODY: begin
                if (acc) begin
                    if (f_head) begin
                        state_next = head_next;
                    end else if (!vc_ok || (f_tail != body_last)) begin
                        state_next = S_IDLE;
                    end else if (f_tail) begin
                        state_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (bus.ready_in) begin
                    state_next = (acc && f_head) ? head_next : S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath strobes: head load, body store, word complete, packet drop.
    always_comb begin
        head_c = 1'b0;
        body_c = 1'b0;
        done_c = 1'b0;
        drop_c = 1'b0;
        case (state)
            S_IDLE, S_HOLD: begin
                if (acc) begin
                    if (f_head) head_c = 1'b1;
                    else        drop_c = 1'b1;
                end
            end
            S_BODY: begin
                if (acc) begin
                    if (f_head) begin
                        drop_c = 1'b1;
                        head_c = 1'b1;
                    end else if (!vc_ok || (f_tail != body_last)) begin
                        drop_c = 1'b1;
                    end else begin
                        body_c = 1'b1;
                        done_c = f_tail;
                    end
                end
            end
            default: ;
        endcase
        // Single-flit packets complete on the head itself.
        if (head_c && (N_FLITS == 1)) begin
            if (f_tail) done_c = 1'b1;
            else        drop_c = 1'b1;
        end
    end

    // Reassembly registers, registered outputs and drop accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q     <= '0;
            idx_q     <= '0;
            vc_q      <= '0;
            dst_q     <= '0;
            data_q    <= '0;
            dst_out_q <= '0;
            vc_out_q  <= '0;
            valid_q   <= 1'b0;
            err_out   <= 1'b0;
            drop_cnt  <= 8'd0;
        end else begin
            if (head_c) begin
                vc_q  <= f_vc;
                dst_q <= f_dst;
                idx_q <= IDX_W'(1);
            end else if (body_c) begin
                idx_q <= idx_q + IDX_W'(1);
            end
            if (head_c || body_c) begin
                buf_q <= buf_c;
            end
            if (done_c) begin
                data_q    <= word_c;
                dst_out_q <= head_c ? f_dst : dst_q;
                vc_out_q  <= head_c ? f_vc  : vc_q;
            end
            valid_q <= (state_next == S_HOLD);
            err_out <= drop_c;
            if (drop_c && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    assign bus.data_out  = data_q;
    assign bus.dst_out   = dst_out_q;
    assign bus.vc_out    = vc_out_q;
    assign bus.valid_out = valid_q;

endmodule
